// File: rtl/ts_pkg.sv
// Shared types and constants for the TS bus poll master.
// The master's state encoding is fixed here so any block that logs or
// decodes the poller state sees the same values.
package ts_pkg;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_DRIVE,
        TS_SAMPLE,
        TS_REPORT
    } ts_poll_state_e;

    localparam int unsigned TS_ADRS_W = 8;
    localparam logic [TS_ADRS_W-1:0] TS_IDLE_ADRS = 8'hFF;

    // Plain-vector state constants for blocks that keep state in logic registers
    localparam logic [1:0] ST_IDLE   = TS_IDLE;
    localparam logic [1:0] ST_DRIVE  = TS_DRIVE;
    localparam logic [1:0] ST_SAMPLE = TS_SAMPLE;
    localparam logic [1:0] ST_REPORT = TS_REPORT;

endpackage

// File: rtl/ts_poll_master_if.sv
// TS bus plus snapshot handshake seen by the poll master.
// master: the sequencer end (drives adrs, samples data, offers the snapshot).
// slave:  the bus/consumer end (answers on data, accepts the snapshot).
interface ts_poll_master_if
    import ts_pkg::*;
#(
    parameter int unsigned N_SLAVES = 2,
    parameter int unsigned ADRS_W   = TS_ADRS_W
);

    logic                start;
    logic                busy;
    logic [ADRS_W-1:0]   adrs;
    logic                data;
    logic                snap_valid;
    logic                snap_ready;
    logic [N_SLAVES-1:0] snap_data;

    modport master (
        input  start,
        output busy,
        output adrs,
        input  data,
        output snap_valid,
        input  snap_ready,
        output snap_data
    );

    modport slave (
        output start,
        input  busy,
        input  adrs,
        output data,
        input  snap_valid,
        output snap_ready,
        input  snap_data
    );

endinterface

// File: rtl/ts_sync2.sv
// Two-flop synchronizer for the asynchronous wired-OR data line.
// Both stages reset to 0.
module ts_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the raw line through two stages to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ts_poll_master.sv
// TS bus poll master: walks ADRS_TABLE, holds each address for a settle
// window, samples the wired-OR data line, and hands the collected bits
// downstream as one snapshot over a valid/ready handshake.
//
// Build option: define TS_POLL_DATA_SYNC_EN to route data through a
// two-flop synchronizer; each address is then held two extra cycles so the
// sampled value belongs to the address being driven.
module ts_poll_master
    import ts_pkg::*;
#(
    parameter int unsigned                   N_SLAVES   = 2,
    parameter int unsigned                   ADRS_W     = TS_ADRS_W,
    // Entry i occupies bits [i*ADRS_W +: ADRS_W]; entry 0 (42) is polled first
    parameter logic [N_SLAVES*ADRS_W-1:0]    ADRS_TABLE = {8'd50, 8'd42},
    parameter logic [ADRS_W-1:0]             IDLE_ADRS  = TS_IDLE_ADRS,
    parameter int unsigned                   SETTLE     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ts_poll_master_if.master  bus
);

`ifdef TS_POLL_DATA_SYNC_EN
    localparam int unsigned EFF_SETTLE = SETTLE + 2;
`else
    localparam int unsigned EFF_SETTLE = SETTLE;
`endif

    localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned CNT_W = (EFF_SETTLE > 1) ? $clog2(EFF_SETTLE) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLAVES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EFF_SETTLE - 1);

    logic [ADRS_W-1:0] adrs_tab [N_SLAVES];

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_tab
        assign adrs_tab[gi] = ADRS_TABLE[gi*ADRS_W +: ADRS_W];
    end

    // Data line as seen by the sampler
    logic data_smp;

`ifdef TS_POLL_DATA_SYNC_EN
    ts_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.data),
        .q     (data_smp)
    );
`else
    assign data_smp = bus.data;
`endif

    logic [1:0]          state_q,      state_d;
    logic [IDX_W-1:0]    idx_q,        idx_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [ADRS_W-1:0]   adrs_q,       adrs_d;
    logic                busy_q,       busy_d;
    logic                snap_valid_q, snap_valid_d;
    logic [N_SLAVES-1:0] snap_data_q,  snap_data_d;
    logic [N_SLAVES-1:0] shadow_q,     shadow_d;

    // Scan sequencing: next state, address, capture and handshake
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        adrs_d       = adrs_q;
        busy_d       = busy_q;
        snap_valid_d = snap_valid_q;
        snap_data_d  = snap_data_q;
        shadow_d     = shadow_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    cnt_d    = '0;
                    adrs_d   = adrs_tab[0];
                    busy_d   = 1'b1;
                    // Fresh snapshot each scan; nothing carries over
                    shadow_d = '0;
                end
            end

            ST_DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                shadow_d[idx_q] = data_smp;
                if (idx_q == LAST_IDX) begin
                    state_d      = ST_REPORT;
                    adrs_d       = IDLE_ADRS;
                    snap_valid_d = 1'b1;
                    snap_data_d  = shadow_d;
                end else begin
                    // Step straight to the next entry, no idle address between
                    state_d = ST_DRIVE;
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    adrs_d  = adrs_tab[idx_d];
                end
            end

            ST_REPORT: begin
                // snap_valid is high throughout REPORT, so ready completes it
                if (bus.snap_ready) begin
                    state_d      = ST_IDLE;
                    snap_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partial scan at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            adrs_q       <= IDLE_ADRS;
            busy_q       <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_data_q  <= '0;
            shadow_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            adrs_q       <= adrs_d;
            busy_q       <= busy_d;
            snap_valid_q <= snap_valid_d;
            snap_data_q  <= snap_data_d;
            shadow_q     <= shadow_d;
        end
    end

    assign bus.adrs       = adrs_q;
    assign bus.busy       = busy_q;
    assign bus.snap_valid = snap_valid_q;
    assign bus.snap_data  = snap_data_q;

endmodule

// File: tb/tb_ts_poll_master.sv
// Bench for ts_poll_master with two bus slaves at addresses 42 and 50.
// Stimulus pushes the expected snapshot and its start cycle into a queue;
// a negedge monitor pops an entry whenever a snapshot appears and checks
// data, latency, the address sequence and busy around that scan.
module tb_ts_poll_master;
    import ts_pkg::*;

    localparam int unsigned N_SLAVES = 2;
    localparam int unsigned ADRS_W   = 8;
    localparam int unsigned SETTLE   = 2;
    localparam logic [15:0] TABLE    = {8'd50, 8'd42};
    localparam logic [7:0]  IDLE_A   = 8'hFF;
    localparam logic [7:0]  S42      = 8'd42;
    localparam logic [7:0]  S50      = 8'd50;

`ifdef TS_POLL_DATA_SYNC_EN
    localparam int HOLD = SETTLE + 3;
`else
    localparam int HOLD = SETTLE + 1;
`endif
    localparam int LAT = N_SLAVES * HOLD + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ts_poll_master_if #(.N_SLAVES(N_SLAVES), .ADRS_W(ADRS_W)) bus ();

    ts_poll_master #(
        .N_SLAVES   (N_SLAVES),
        .ADRS_W     (ADRS_W),
        .ADRS_TABLE (TABLE),
        .IDLE_ADRS  (IDLE_A),
        .SETTLE     (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // slave_d[0] is the S42 answer, slave_d[1] the S50 answer
    logic [1:0] slave_d = 2'b00;
    assign bus.data = ((bus.adrs == S42) && slave_d[0]) || ((bus.adrs == S50) && slave_d[1]);

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N_SLAVES-1:0] snap;
        int                  start_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
    endtask

    // Address the master should drive j cycles after the start cycle
    function automatic logic [7:0] exp_adrs(input int j);
        int e;
        e = (j - 1) / HOLD;
        if (e == 0) return S42;
        if (e == 1) return S50;
        return IDLE_A;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] adrs_log [64];
    logic       busy_log [64];

    initial begin
        bit   prev_valid;
        bit   hs_pend;
        exp_t cur;
        prev_valid = 0;
        hs_pend    = 0;
        cur.snap   = '0;
        cur.start_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0;
                hs_pend    = 0;
            end else begin
                adrs_log[cyc % 64] = bus.adrs;
                busy_log[cyc % 64] = bus.busy;
                if (hs_pend) begin
                    check("post_hs_valid", 32'(bus.snap_valid), 32'(0));
                    check("post_hs_busy", 32'(bus.busy), 32'(0));
                    hs_pend = 0;
                end
                if (bus.snap_valid) begin
                    if (!prev_valid) begin
                        if (exp_q.size() == 0) begin
                            fail_now("expected_snapshot_entry");
                        end else begin
                            int span;
                            int bad_a;
                            int bad_b;
                            cur  = exp_q.pop_front();
                            span = cyc - cur.start_cyc;
                            check("latency", 32'(span), 32'(LAT));
                            if (span > 0 && span < 60) begin
                                bad_a = 0;
                                bad_b = (busy_log[cur.start_cyc % 64] !== 1'b0) ? 1 : 0;
                                for (int j = 1; j < span; j++) begin
                                    if (adrs_log[(cur.start_cyc + j) % 64] !== exp_adrs(j))
                                        bad_a++;
                                end
                                for (int j = 1; j <= span; j++) begin
                                    if (busy_log[(cur.start_cyc + j) % 64] !== 1'b1)
                                        bad_b++;
                                end
                                check("adrs_seq_bad_cycles", 32'(bad_a), 32'(0));
                                check("busy_bad_cycles", 32'(bad_b), 32'(0));
                            end
                        end
                    end
                    check("snap_data", 32'(bus.snap_data), 32'(cur.snap));
                    check("report_adrs", 32'(bus.adrs), 32'(IDLE_A));
                    if (bus.snap_ready) hs_pend = 1;
                end
                prev_valid = bus.snap_valid;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || bus.snap_valid) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) fail_now("idle_timeout");
    endtask

    task automatic launch(input logic [1:0] d);
        exp_t e;
        slave_d   = d;
        bus.start = 1'b1;
        e.snap      = d;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_scan(input logic [1:0] d, input int delay, input bit extra_start);
        int n;
        tick();
        wait_idle();
        launch(d);
        if (extra_start) begin
            // Lands in DRIVE; must be ignored
            tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        n = 0;
        while (!bus.snap_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail_now("snap_valid_timeout");
        repeat (delay) tick();
        bus.snap_ready = 1'b1;
        tick();
        bus.snap_ready = 1'b0;
    endtask

    initial begin
        int n;
        int s;
        exp_t e;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.snap_ready = 1'b0;
        repeat (3) tick();
        check("rst_adrs", 32'(bus.adrs), 32'(IDLE_A));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_valid", 32'(bus.snap_valid), 32'(0));
        check("rst_snap_data", 32'(bus.snap_data), 32'(0));
        rst_n = 1'b1;
        tick();

        // d50=1, d42=0 -> 2'b10
        run_scan(2'b10, 0, 0);
        // Backpressure: d50=0, d42=1, ready low for 10 cycles
        run_scan(2'b01, 10, 0);
        // Start pulse mid-scan is ignored
        run_scan(2'b10, 0, 1);

        // Reset mid-scan while adrs is 42
        tick();
        wait_idle();
        launch(2'b11);
        n = 0;
        while (bus.adrs != S42 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) fail_now("reach_adrs42");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_adrs", 32'(bus.adrs), 32'(IDLE_A));
        check("midrst_busy", 32'(bus.busy), 32'(0));
        check("midrst_valid", 32'(bus.snap_valid), 32'(0));
        check("midrst_snap_data", 32'(bus.snap_data), 32'(0));
        exp_q.delete();
        repeat (2) tick();
        check("rst_hold_adrs", 32'(bus.adrs), 32'(IDLE_A));
        rst_n = 1'b1;
        run_scan(2'b11, 0, 0);

        // Clear old bits: all-zero scan right after all-ones
        run_scan(2'b00, 1, 0);

        // Continuous start with ready high: three back-to-back scans
        tick();
        wait_idle();
        slave_d        = 2'($urandom);
        bus.snap_ready = 1'b1;
        bus.start      = 1'b1;
        s = cyc;
        for (int k = 0; k < 3; k++) begin
            e.snap      = slave_d;
            e.start_cyc = s + k * (LAT + 1);
            exp_q.push_back(e);
        end
        repeat (2 * (LAT + 1)) tick();
        tick();
        bus.start = 1'b0;
        wait_idle();
        bus.snap_ready = 1'b0;

        // Randomized scans
        for (int i = 0; i < 20; i++) begin
            run_scan(2'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        repeat (LAT + 5) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
